// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus target: FSM states, CA field positions,
// register map and CR0 latency field limits.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_RD,
    ST_WR
  } state_e;

  localparam int CA_RW_BIT    = 47;
  localparam int CA_SPACE_BIT = 46;
  localparam int CA_ROW_HI    = 44;
  localparam int CA_ROW_LO    = 16;
  localparam int CA_COL_HI    = 2;

  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_ID1 = 32'h0000_0001;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;
  localparam logic [31:0] REG_CR1 = 32'h0000_0801;

  localparam int CR0_LAT_LSB = 4;
  localparam int CR0_LAT_MSB = 6;
  localparam int LAT_MIN     = 3;
  localparam int LAT_MAX     = 7;

  function automatic logic lat_legal(input logic [2:0] f);
    return (int'(f) >= LAT_MIN) && (int'(f) <= LAT_MAX);
  endfunction

endpackage

// File: rtl/hyperbus_edge_det.sv
// Two-stage input synchroniser for the HyperBus clock and an aligned data vector,
// with rise/fall detection on the delayed clock.
module hyperbus_edge_det #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ck_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] d1_q, d2_q;
  logic         ck1_q, ck2_q, ck3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d1_q  <= RST_VAL;
      d2_q  <= RST_VAL;
      ck1_q <= 1'b0;
      ck2_q <= 1'b0;
      ck3_q <= 1'b0;
    end else begin
      d1_q  <= d_i;
      d2_q  <= d1_q;
      ck1_q <= ck_i;
      ck2_q <= ck1_q;
      ck3_q <= ck2_q;
    end
  end

  assign q_o    = d2_q;
  assign rise_o = ck2_q & ~ck3_q;
  assign fall_o = ~ck2_q & ck3_q;

endmodule

// File: rtl/hyperbus_target_ram.sv
// HyperBus target serving on-chip BRAM and a small register space from oversampled pins.
// Define HBT_FIXED_LATENCY_EN for fixed 2x latency with RWDS=11 during CA.
module hyperbus_target_ram
  import hyperbus_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter int          LAT_RESET = 4,
  parameter logic [15:0] ID0_VAL   = 16'h0C81,
  parameter logic [15:0] ID1_VAL   = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_clk_p,
  input  logic        dram_cs,
  input  logic [15:0] dram_dq_i,
  output logic [15:0] dram_dq_o,
  output logic        dram_dq_oe,
  input  logic [1:0]  dram_rwds_i,
  output logic [1:0]  dram_rwds_o,
  output logic        dram_rwds_oe,
  output logic        busy,
  output logic        err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] CR0_RST = {9'h0, 3'(LAT_RESET), 4'hF};
`ifdef HBT_FIXED_LATENCY_EN
  localparam logic [1:0]  RWDS_CA = 2'b11;
`else
  localparam logic [1:0]  RWDS_CA = 2'b00;
`endif

  logic [18:0] pins_s;
  logic        ck_rise, ck_fall, ck_edge, cs_s, cs_fall;
  logic [15:0] dq_s;
  logic [1:0]  rwds_s;

  hyperbus_edge_det #(.W(19), .RST_VAL(19'h1)) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .ck_i   (dram_clk_p),
    .d_i    ({dram_rwds_i, dram_dq_i, dram_cs}),
    .q_o    (pins_s),
    .rise_o (ck_rise),
    .fall_o (ck_fall)
  );

  assign cs_s    = pins_s[0];
  assign dq_s    = pins_s[16:1];
  assign rwds_s  = pins_s[18:17];
  assign ck_edge = ck_rise | ck_fall;

  state_e      state_q;
  logic [1:0]  ca_cnt_q;
  logic        rw_q, space_q, cs_q, tgl_q;
  logic [12:0] row_hi_q;
  logic [15:0] row_lo_q;
  logic [31:0] addr_q, ca_addr;
  logic [3:0]  lat_q, lat_load;
  logic [15:0] cr0_q, cr1_q, cr0_wr, reg_rdata, rd_word, mem_rdata_q;
  logic [15:0] dq_o_q;
  logic [1:0]  rwds_o_q;
  logic        dq_oe_q, rwds_oe_q, busy_q, err_q, mem_we;
  logic [15:0] mem [DEPTH];

  assign cs_fall = ~cs_s & cs_q;
  assign ca_addr = {row_hi_q, row_lo_q, dq_s[CA_COL_HI:0]};
`ifdef HBT_FIXED_LATENCY_EN
  assign lat_load = {cr0_q[CR0_LAT_MSB:CR0_LAT_LSB], 1'b0};
`else
  assign lat_load = {1'b0, cr0_q[CR0_LAT_MSB:CR0_LAT_LSB]};
`endif
  // An illegal latency field keeps the old field but the rest of the write lands.
  assign cr0_wr = {dq_s[15:7],
                   lat_legal(dq_s[6:4]) ? dq_s[6:4] : cr0_q[CR0_LAT_MSB:CR0_LAT_LSB],
                   dq_s[3:0]};

  always_comb begin
    reg_rdata = 16'h0000;
    case (addr_q)
      REG_ID0: reg_rdata = ID0_VAL;
      REG_ID1: reg_rdata = ID1_VAL;
      REG_CR0: reg_rdata = cr0_q;
      REG_CR1: reg_rdata = cr1_q;
      default: reg_rdata = 16'h0000;
    endcase
  end

  assign rd_word = space_q ? reg_rdata : mem_rdata_q;
  assign mem_we  = (state_q == ST_WR) && ck_edge && !cs_s && !space_q && !rst;

  // addr_q always points at the next word, so the read port prefetches it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!rwds_s[0]) mem[addr_q[AW-1:0]][7:0]  <= dq_s[7:0];
      if (!rwds_s[1]) mem[addr_q[AW-1:0]][15:8] <= dq_s[15:8];
    end
    mem_rdata_q <= mem[addr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ca_cnt_q  <= 2'd0;
      rw_q      <= 1'b0;
      space_q   <= 1'b0;
      row_hi_q  <= '0;
      row_lo_q  <= '0;
      addr_q    <= '0;
      lat_q     <= '0;
      tgl_q     <= 1'b0;
      cs_q      <= 1'b1;
      cr0_q     <= CR0_RST;
      cr1_q     <= 16'h0001;
      dq_o_q    <= '0;
      rwds_o_q  <= '0;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cs_q  <= cs_s;
      err_q <= 1'b0;
      if (state_q != ST_IDLE && cs_s) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        dq_oe_q   <= 1'b0;
        rwds_oe_q <= 1'b0;
        dq_o_q    <= '0;
        rwds_o_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (cs_fall) begin
            state_q   <= ST_CA;
            busy_q    <= 1'b1;
            ca_cnt_q  <= 2'd0;
            rwds_oe_q <= 1'b1;
            rwds_o_q  <= RWDS_CA;
          end
          ST_CA: if (ck_edge) begin
            ca_cnt_q <= ca_cnt_q + 2'd1;
            if (ca_cnt_q == 2'd0) begin
              rw_q     <= dq_s[CA_RW_BIT-32];
              space_q  <= dq_s[CA_SPACE_BIT-32];
              row_hi_q <= dq_s[CA_ROW_HI-32:0];
            end else if (ca_cnt_q == 2'd1) begin
              row_lo_q <= dq_s;
            end else begin
              addr_q    <= ca_addr;
              tgl_q     <= 1'b0;
              dq_o_q    <= '0;
              rwds_o_q  <= '0;
              dq_oe_q   <= rw_q;
              rwds_oe_q <= rw_q;
              lat_q     <= lat_load;
              state_q   <= (!rw_q && space_q) ? ST_WR : ST_LAT;
            end
          end
          ST_LAT: if (ck_rise) begin
            lat_q <= lat_q - 4'd1;
            if (lat_q == 4'd1) state_q <= rw_q ? ST_RD : ST_WR;
          end
          ST_RD: if (ck_edge) begin
            dq_o_q   <= rd_word;
            rwds_o_q <= {2{tgl_q}};
            tgl_q    <= ~tgl_q;
            addr_q   <= addr_q + 32'd1;
          end
          ST_WR: if (ck_edge) begin
            addr_q <= addr_q + 32'd1;
            if (space_q) begin
              if (addr_q == REG_CR0) begin
                cr0_q <= cr0_wr;
                err_q <= !lat_legal(dq_s[6:4]);
              end else if (addr_q == REG_CR1) begin
                cr1_q <= dq_s;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dram_dq_o    = dq_o_q;
  assign dram_dq_oe   = dq_oe_q;
  assign dram_rwds_o  = rwds_o_q;
  assign dram_rwds_oe = rwds_oe_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_hyperbus_target_ram.sv
// Scoreboard bench for hyperbus_target_ram: host-side driver pushes expected read words,
// a negedge monitor pops and compares them when the pin response is due.
module tb_hyperbus_target_ram;

  localparam int          DEPTH = 64;
  localparam logic [15:0] ID0   = 16'h0C81;
  localparam logic [15:0] ID1   = 16'h0001;
`ifdef HBT_FIXED_LATENCY_EN
  localparam int          LMUL    = 2;
  localparam logic [1:0]  CA_RWDS = 2'b11;
`else
  localparam int          LMUL    = 1;
  localparam logic [1:0]  CA_RWDS = 2'b00;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        dram_clk_p = 1'b0, dram_cs = 1'b1;
  logic [15:0] dram_dq_i = '0;
  logic [1:0]  dram_rwds_i = '0;
  logic [15:0] dram_dq_o;
  logic        dram_dq_oe, dram_rwds_oe, busy, err;
  logic [1:0]  dram_rwds_o;

  hyperbus_target_ram #(.DEPTH(DEPTH), .LAT_RESET(4), .ID0_VAL(ID0), .ID1_VAL(ID1)) dut (
    .clk(clk), .rst(rst), .dram_clk_p(dram_clk_p), .dram_cs(dram_cs),
    .dram_dq_i(dram_dq_i), .dram_dq_o(dram_dq_o), .dram_dq_oe(dram_dq_oe),
    .dram_rwds_i(dram_rwds_i), .dram_rwds_o(dram_rwds_o), .dram_rwds_oe(dram_rwds_oe),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0, err_cnt = 0;

  logic [15:0] mem_m [DEPTH];
  logic [15:0] cr0_m = 16'h004F, cr1_m = 16'h0001;
  logic [15:0] wd [64];
  logic [1:0]  wm [64];

  typedef struct {
    logic [15:0] dq;
    logic        tg;
    longint      due;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (err) err_cnt++;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_chk++;
      n_err++;
      $display("FAIL rd_missed: word %h due at %0d not sampled", exp_q[0].dq, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_mon = exp_q.pop_front();
      chk("rd_dq", {15'h0, dram_dq_oe, dram_dq_o}, {15'h0, 1'b1, e_mon.dq});
      chk("rd_rwds", {29'h0, dram_rwds_oe, dram_rwds_o}, {29'h0, 1'b1, e_mon.tg, e_mon.tg});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hb_edge(input logic [15:0] d, input logic [1:0] m);
    dram_dq_i   = d;
    dram_rwds_i = m;
    dram_clk_p  = ~dram_clk_p;
    wait_clk(2);
  endtask

  function automatic logic [15:0] reg_val(input logic [31:0] a);
    case (a)
      32'h0000: return ID0;
      32'h0001: return ID1;
      32'h0800: return cr0_m;
      32'h0801: return cr1_m;
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic int lat_edges(input logic rd, input logic space);
    if (!rd && space) return 0;
    return 2 * LMUL * int'(cr0_m[6:4]);
  endfunction

  task automatic start_ca(input logic rd, input logic space, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, space, 1'b0, a[31:3], 13'h0, a[2:0]};
    dram_cs = 1'b0;
    wait_clk(4);
    chk("busy_ca", {31'h0, busy}, 32'h1);
    chk("rwds_ca", {29'h0, dram_rwds_oe, dram_rwds_o}, {29'h0, 1'b1, CA_RWDS});
    hb_edge(ca[47:32], 2'b00);
    hb_edge(ca[31:16], 2'b00);
    hb_edge(ca[15:0], 2'b00);
  endtask

  task automatic hb_end();
    dram_cs = 1'b1;
    wait_clk(1);
    dram_clk_p = 1'b0;
    wait_clk(6);
    chk("busy_end", {31'h0, busy}, 32'h0);
  endtask

  task automatic rd_burst(input logic space, input logic [31:0] a, input int n);
    exp_t e;
    logic [31:0] aa;
    start_ca(1'b1, space, a);
    repeat (lat_edges(1'b1, space)) hb_edge(16'h0, 2'b00);
    for (int i = 0; i < n; i++) begin
      aa   = a + 32'(i);
      e.dq = space ? reg_val(aa) : mem_m[int'(aa % DEPTH)];
      e.tg = i[0];
      e.due = cyc + 3;
      exp_q.push_back(e);
      hb_edge(16'h0, 2'b00);
    end
    hb_end();
  endtask

  task automatic wr_burst(input logic space, input logic [31:0] a, input int n);
    int exp_err, err0, idx;
    logic [31:0] aa;
    exp_err = 0;
    err0 = err_cnt;
    start_ca(1'b0, space, a);
    repeat (lat_edges(1'b0, space)) hb_edge(16'h0, 2'b00);
    for (int i = 0; i < n; i++) begin
      hb_edge(wd[i], wm[i]);
      aa = a + 32'(i);
      if (space) begin
        if (aa == 32'h0800) begin
          if (wd[i][6:4] >= 3'd3) cr0_m = wd[i];
          else begin
            cr0_m = {wd[i][15:7], cr0_m[6:4], wd[i][3:0]};
            exp_err++;
          end
        end else if (aa == 32'h0801) cr1_m = wd[i];
      end else begin
        idx = int'(aa % DEPTH);
        if (!wm[i][0]) mem_m[idx][7:0]  = wd[i][7:0];
        if (!wm[i][1]) mem_m[idx][15:8] = wd[i][15:8];
      end
    end
    hb_end();
    chk("err_pulses", 32'(err_cnt - err0), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, ra;
    int n;
    wait_clk(5);
    chk("rst_outs_during", {12'h0, dram_dq_o, dram_dq_oe, dram_rwds_o, dram_rwds_oe, busy, err}, 32'h0);
    rst = 1'b0;
    wait_clk(3);
    chk("rst_outs", {12'h0, dram_dq_o, dram_dq_oe, dram_rwds_o, dram_rwds_oe, busy, err}, 32'h0);

    // Known contents everywhere.
    for (int i = 0; i < DEPTH; i++) begin wd[i] = 16'(i * 3 + 1); wm[i] = 2'b00; end
    wr_burst(1'b0, 32'h0, DEPTH);

    rd_burst(1'b1, 32'h0800, 2);
    rd_burst(1'b1, 32'h0000, 1);
    rd_burst(1'b1, 32'h0001, 2);

    wd[0] = 16'h1337; wd[1] = 16'hCAFE; wm[0] = 2'b00; wm[1] = 2'b00;
    wr_burst(1'b0, 32'd4, 2);
    rd_burst(1'b0, 32'd4, 2);

    wd[0] = 16'h006F;
    wr_burst(1'b1, 32'h0800, 1);
    rd_burst(1'b0, 32'd4, 3);
    wd[0] = 16'h002F;
    wr_burst(1'b1, 32'h0800, 1);
    rd_burst(1'b1, 32'h0800, 1);

    wd[0] = 16'hFFFF; wm[0] = 2'b00;
    wr_burst(1'b0, 32'd8, 1);
    wd[0] = 16'hAB12; wm[0] = 2'b10;
    wr_burst(1'b0, 32'd8, 1);
    rd_burst(1'b0, 32'd8, 1);

    wd[0] = 16'h1111; wd[1] = 16'h2222; wm[0] = 2'b00; wm[1] = 2'b00;
    wr_burst(1'b0, 32'(DEPTH - 1), 2);
    rd_burst(1'b0, 32'd0, 1);
    rd_burst(1'b0, 32'(DEPTH - 1), 3);
    rd_burst(1'b0, 32'(DEPTH + 4), 2);

    wd[0] = 16'h5555;
    wr_burst(1'b1, 32'h0000, 1);
    rd_burst(1'b1, 32'h0000, 3);

    // Abort during read latency, then a clean transaction.
    start_ca(1'b1, 1'b0, 32'd4);
    repeat (3) hb_edge(16'h0, 2'b00);
    chk("lat_oe", {30'h0, dram_dq_oe, dram_rwds_oe}, 32'h3);
    dram_cs = 1'b1;
    wait_clk(3);
    chk("abort_release", {29'h0, dram_dq_oe, dram_rwds_oe, busy}, 32'h0);
    dram_clk_p = 1'b0;
    wait_clk(4);
    rd_burst(1'b0, 32'd4, 2);

    // CS pulse with no clock edges.
    n = err_cnt;
    dram_cs = 1'b0;
    wait_clk(4);
    chk("busy_noedge", {31'h0, busy}, 32'h1);
    dram_cs = 1'b1;
    wait_clk(4);
    chk("idle_noedge", {30'h0, busy, dram_rwds_oe}, 32'h0);
    chk("err_noedge", 32'(err_cnt - n), 32'h0);

    // Reset mid-transaction.
    start_ca(1'b1, 1'b0, 32'd8);
    hb_edge(16'h0, 2'b00);
    hb_edge(16'h0, 2'b00);
    rst = 1'b1;
    dram_cs = 1'b1;
    dram_clk_p = 1'b0;
    wait_clk(2);
    chk("rst_mid", {29'h0, dram_dq_oe, dram_rwds_oe, busy}, 32'h0);
    rst = 1'b0;
    cr0_m = 16'h004F;
    cr1_m = 16'h0001;
    wait_clk(4);
    rd_burst(1'b1, 32'h0800, 2);
    rd_burst(1'b0, 32'd8, 1);

    for (int it = 0; it < 24; it++) begin
      r  = $urandom_range(0, 9);
      ra = $urandom_range(0, 2 * DEPTH - 1);
      n  = $urandom_range(1, 6);
      if (r < 4) begin
        for (int i = 0; i < n; i++) begin
          wd[i] = 16'($urandom);
          wm[i] = 2'($urandom_range(0, 3));
        end
        wr_burst(1'b0, ra, n);
      end else if (r < 8) begin
        rd_burst(1'b0, ra, n);
      end else if (r == 8) begin
        r = $urandom;
        wd[0] = {r[15:7], 3'($urandom_range(1, 7)), r[3:0]};
        wr_burst(1'b1, 32'h0800, 1);
      end else begin
        rd_burst(1'b1, 32'h0800, 2);
      end
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) wait_clk(1);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expected words never checked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
